// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: datapath width, access size
// encodings, FSM states and small helpers for byte-lane handling.
package mem_pkg;

  localparam int XLEN = 64;

  localparam logic [1:0] SIZE_BYTE   = 2'b00;
  localparam logic [1:0] SIZE_HALF   = 2'b01;
  localparam logic [1:0] SIZE_WORD   = 2'b10;
  localparam logic [1:0] SIZE_DOUBLE = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  // Unshifted byte-enable pattern for an access of the given size.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      SIZE_BYTE: m = 8'h01;
      SIZE_HALF: m = 8'h03;
      SIZE_WORD: m = 8'h0F;
      default:   m = 8'hFF;
    endcase
    return m;
  endfunction

  // True when the byte offset is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic mis;
    case (size)
      SIZE_HALF:   mis = off[0];
      SIZE_WORD:   mis = |off[1:0];
      SIZE_DOUBLE: mis = |off;
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: pulls the addressed lane out of a doubleword read and
// sign- or zero-extends it to the full register width.
module load_align
  import mem_pkg::*;
#(
  parameter int XLEN = mem_pkg::XLEN
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] lane;

  // Shift the addressed bytes down to bit 0, then extend according to size.
  always_comb begin
    lane   = rdata >> {offset, 3'b000};
    result = lane;
    case (size)
      SIZE_BYTE: result = is_unsigned ? {{(XLEN-8){1'b0}}, lane[7:0]}
                                      : {{(XLEN-8){lane[7]}}, lane[7:0]};
      SIZE_HALF: result = is_unsigned ? {{(XLEN-16){1'b0}}, lane[15:0]}
                                      : {{(XLEN-16){lane[15]}}, lane[15:0]};
      SIZE_WORD: result = is_unsigned ? {{(XLEN-32){1'b0}}, lane[31:0]}
                                      : {{(XLEN-32){lane[31]}}, lane[31:0]};
      default:   result = lane;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access pipeline stage: passes ALU results through in one cycle,
// issues aligned load/store requests to memory and waits for the ack, and
// flags misaligned or contradictory memory operations as faults.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN = mem_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_alu_y,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_wr,
  input  logic            in_mem_rd,
  input  logic            in_mem_wr,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic            flush,
  output logic            out_valid,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_result,
  output logic            out_reg_wr,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_be,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            fault
);

  state_e state_q, state_d;

  logic            is_mem;
  logic            illegal;
  logic            accept;
  logic [2:0]      off;
  logic [XLEN-1:0] load_result;

  logic            out_valid_q, out_valid_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic [XLEN-1:0] out_result_q, out_result_d;
  logic            out_reg_wr_q, out_reg_wr_d;
  logic            fault_q, fault_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]      mem_be_q, mem_be_d;

  // Context of the outstanding memory operation, needed when the ack arrives.
  logic            pend_load_q, pend_load_d;
  logic            pend_reg_wr_q, pend_reg_wr_d;
  logic [4:0]      pend_rd_q, pend_rd_d;
  logic [1:0]      pend_size_q, pend_size_d;
  logic            pend_unsigned_q, pend_unsigned_d;
  logic [2:0]      pend_off_q, pend_off_d;

  assign off      = in_alu_y[2:0];
  assign is_mem   = in_mem_rd | in_mem_wr;
  assign illegal  = (in_mem_rd & in_mem_wr) | is_misaligned(in_size, off);
  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid & in_ready & ~flush;

  assign out_valid  = out_valid_q;
  assign out_rd     = out_rd_q;
  assign out_result = out_result_q;
  assign out_reg_wr = out_reg_wr_q;
  assign fault      = fault_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata       (mem_rdata),
    .offset      (pend_off_q),
    .size        (pend_size_q),
    .is_unsigned (pend_unsigned_q),
    .result      (load_result)
  );

  // FSM state register; reset aborts any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Enter REQ on an accepted legal memory op, leave on ack; flush cannot abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && is_mem && !illegal) state_d = ST_REQ;
      ST_REQ:  if (mem_ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values: writeback pulses, memory request fields.
  always_comb begin
    out_valid_d     = 1'b0;
    fault_d         = 1'b0;
    out_rd_d        = out_rd_q;
    out_result_d    = out_result_q;
    out_reg_wr_d    = out_reg_wr_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_be_d        = mem_be_q;
    pend_load_d     = pend_load_q;
    pend_reg_wr_d   = pend_reg_wr_q;
    pend_rd_d       = pend_rd_q;
    pend_size_d     = pend_size_q;
    pend_unsigned_d = pend_unsigned_q;
    pend_off_d      = pend_off_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            out_valid_d  = 1'b1;
            out_result_d = in_alu_y;
            out_rd_d     = in_rd;
            out_reg_wr_d = in_reg_wr;
          end else if (illegal) begin
            out_valid_d  = 1'b1;
            fault_d      = 1'b1;
            out_result_d = '0;
            out_rd_d     = in_rd;
            out_reg_wr_d = 1'b0;
          end else begin
            mem_req_d       = 1'b1;
            mem_we_d        = in_mem_wr;
            mem_addr_d      = {in_alu_y[XLEN-1:3], 3'b000};
            mem_wdata_d     = in_wdata << {off, 3'b000};
            mem_be_d        = size_mask(in_size) << off;
            pend_load_d     = in_mem_rd;
            pend_reg_wr_d   = in_reg_wr;
            pend_rd_d       = in_rd;
            pend_size_d     = in_size;
            pend_unsigned_d = in_unsigned;
            pend_off_d      = off;
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_be_d     = 8'h00;
          out_valid_d  = 1'b1;
          out_rd_d     = pend_rd_q;
          out_reg_wr_d = pend_load_q & pend_reg_wr_q;
          out_result_d = pend_load_q ? load_result : '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; everything visible clears immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q     <= 1'b0;
      out_rd_q        <= '0;
      out_result_q    <= '0;
      out_reg_wr_q    <= 1'b0;
      fault_q         <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_be_q        <= '0;
      pend_load_q     <= 1'b0;
      pend_reg_wr_q   <= 1'b0;
      pend_rd_q       <= '0;
      pend_size_q     <= '0;
      pend_unsigned_q <= 1'b0;
      pend_off_q      <= '0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_rd_q        <= out_rd_d;
      out_result_q    <= out_result_d;
      out_reg_wr_q    <= out_reg_wr_d;
      fault_q         <= fault_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_be_q        <= mem_be_d;
      pend_load_q     <= pend_load_d;
      pend_reg_wr_q   <= pend_reg_wr_d;
      pend_rd_q       <= pend_rd_d;
      pend_size_q     <= pend_size_d;
      pend_unsigned_q <= pend_unsigned_d;
      pend_off_q      <= pend_off_d;
    end
  end

endmodule
